ram_dp: RTL and testbench
=========================

# ram_dp

Parametrised simple-dual-port synchronous RAM: one write port with byte enables and one independent read port. It adds a configurable read latency, a defined read/write collision mode, and a hardware clear sequencer that initialises every location after reset or on request. It is the drop-in successor to the single-port `ram` for buffers and register files that need concurrent read and write.

## Interface
- DATA_WIDTH, 32: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 4: address width; depth = 2**ADDR_WIDTH.
- OUT_REG, 0: 0 gives 1-cycle read latency; 1 adds an output register for 2-cycle latency.
- WRITE_FIRST, 0: same-address collision policy. 0 returns old data; 1 returns newly written data.
- CLEAR_VALUE, 0: DATA_WIDTH-bit value written to every location by the clear sequencer.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clear_req  input  1  single-cycle request to start a full clear; honoured only when idle.
- busy  output  1  high while the clear sequencer runs.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_be  input  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i].
- wr_data  input  DATA_WIDTH  write data.
- rd_en  input  1  read strobe.
- rd_addr  input  ADDR_WIDTH  read address.
- rd_data  output  DATA_WIDTH  read data, held until the next completed read.
- rd_valid  output  1  one-cycle pulse marking rd_data updated.

## Operation
- FSM states: CLEAR and IDLE.
  - Reset drives the FSM to CLEAR with clr_addr=0.
  - In CLEAR, each cycle writes CLEAR_VALUE to clr_addr (all bytes) and increments clr_addr.
  - After writing address 2**ADDR_WIDTH-1, the FSM moves to IDLE.
  - In IDLE, clear_req=1 moves the FSM to CLEAR with clr_addr=0.
- busy = (state==CLEAR).
- While busy:
  - wr_en and rd_en are ignored: no array update, no new rd_valid.
  - clear_req is ignored.
  - Reads accepted before busy rose still complete normally.
- Write in IDLE with wr_en=1: for each i with wr_be[i]=1, the byte is updated. wr_be=0 leaves the word unchanged.
- Read in IDLE with rd_en=1 samples the array at rd_addr. The result appears on rd_data with rd_valid=1 after the read latency.
- Collision: rd_en and wr_en in the same cycle with rd_addr==wr_addr.
  - WRITE_FIRST=0: rd_data returns the pre-write word.
  - WRITE_FIRST=1: rd_data returns the byte-merged result, i.e. new bytes where wr_be=1 and old bytes elsewhere.
- Different-address simultaneous read and write are fully independent.
- The array itself is not reset; contents are defined only after the first clear completes. Reads of cleared locations return CLEAR_VALUE.

## Timing
- Reset values (asynchronous, while rst_n=0): busy=1, rd_data=0, rd_valid=0, all pipeline stages cleared.
- Clear duration: 2**ADDR_WIDTH cycles.
  - busy stays high from reset deassertion through the edge that writes the last address, then falls.
  - Following clear_req, busy rises the cycle after the request edge.
- Read latency, measured from the rd_en edge:
  - 1 cycle when OUT_REG=0.
  - 2 cycles when OUT_REG=1.
  - One read per cycle is sustained with back-to-back rd_valid.
- Write latency: data is visible to a read issued on the next edge. Same-edge visibility is governed by WRITE_FIRST.
- rd_valid never asserts without a matching accepted rd_en.
- Reset asserted mid-clear or mid-read:
  - All state returns to reset values immediately.
  - The clear restarts from address 0 after deassertion.
  - In-flight reads are dropped.
- clear_req coincident with wr_en/rd_en in IDLE: the access on that edge is performed, then the clear starts. The clear overwrites the written location.

## Test plan
- Reset/clear, ADDR_WIDTH=4, CLEAR_VALUE=32'h0: release rst_n -> busy high exactly 16 cycles; a subsequent read of every address returns 0.
- Byte enables: write 32'h11223344 to addr 3 with be=4'hF, then 32'hAABBCCDD with be=4'b0101 -> read addr 3 returns 32'h11BB33DD with rd_valid one cycle later (OUT_REG=0).
- Collision: addr 5 holds 32'h0; same-cycle write 32'hCAFEF00D (be=4'hF) and read of addr 5 -> returns 32'h0 with WRITE_FIRST=0 and 32'hCAFEF00D with WRITE_FIRST=1.
- Latency/throughput with OUT_REG=1: back-to-back reads of addrs 0,1,2 holding 8'hAA,8'hBB,8'hCC -> rd_valid high on cycles +2,+3,+4 with data AA,BB,CC in order.
- clear_req in IDLE after filling all locations with 32'hFFFFFFFF -> busy 16 cycles; writes during busy leave no effect; all reads afterwards return CLEAR_VALUE.
- Reset at clear cycle 7 -> busy stays 1, rd_valid=0; after release the full 16-cycle sweep reruns and all reads return CLEAR_VALUE.

Source files
------------

// File: rtl/ram_dp_if.sv
// ram_dp_if: groups the clear control, write port and read port of ram_dp.
// The master drives requests and data, and the slave (the RAM) returns busy and read data.
interface ram_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                    clear_req;
  logic                    busy;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH/8-1:0] wr_be;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic                    rd_en;
  logic [ADDR_WIDTH-1:0]   rd_addr;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_valid;

  modport master (
    output clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  busy, rd_data, rd_valid
  );

  modport slave (
    input  clear_req, wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output busy, rd_data, rd_valid
  );
endinterface

// File: rtl/ram_dp.sv
// ram_dp: simple-dual-port synchronous RAM with byte enables, optional output
// register, selectable collision policy and a hardware clear sequencer that
// sweeps every location after reset or on request.
module ram_dp #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 4,
  parameter int                    OUT_REG     = 0,
  parameter int                    WRITE_FIRST = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input logic      clk,
  input logic      rst_n,
  ram_dp_if.slave  bus
);
  localparam int                    NBYTES    = DATA_WIDTH / 8;
  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state;
  state_t                state_next;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic [ADDR_WIDTH-1:0] clr_addr_next;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  idle;
  logic                  wr_ok;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  // State and sweep-address register; reset always restarts the sweep at address 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
    end
  end

  // Next state: sweep every address once, then wait in IDLE for a clear request
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    case (state)
      CLEAR: begin
        clr_addr_next = clr_addr + ADDR_WIDTH'(1);
        if (clr_addr == LAST_ADDR) state_next = IDLE;
      end
      IDLE: begin
        if (bus.clear_req) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
        end
      end
      default: state_next = CLEAR;
    endcase
  end

  // State decode: user accesses are only accepted while the sweep is not running
  always_comb begin
    idle     = (state == IDLE);
    wr_ok    = idle && bus.wr_en;
    rd_ok    = idle && bus.rd_en;
    bus.busy = !idle;
  end

  // Byte-merged write word and the read word, including the same-address collision policy
  always_comb begin
    wr_merged = mem[bus.wr_addr];
    for (int i = 0; i < NBYTES; i++) begin
      if (bus.wr_be[i]) wr_merged[8*i +: 8] = bus.wr_data[8*i +: 8];
    end
    rd_word = mem[bus.rd_addr];
    if ((WRITE_FIRST != 0) && wr_ok && (bus.wr_addr == bus.rd_addr)) rd_word = wr_merged;
  end

  // Storage array (not reset): the sweep owns it while busy, otherwise the write port
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[clr_addr] <= CLEAR_VALUE;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= wr_merged;
    end
  end

  // First read stage: captures the read word and holds it until the next accepted read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) s1_data <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      // Optional output register adding one cycle of read latency
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign bus.rd_valid = s2_valid;
      assign bus.rd_data  = s2_data;
    end else begin : g_no_out_reg
      assign bus.rd_valid = s1_valid;
      assign bus.rd_data  = s1_data;
    end
  endgenerate
endmodule

// File: tb/tb_ram_dp.sv
// tb_ram_dp: drives two ram_dp instances with identical stimulus
// (OUT_REG=0/WRITE_FIRST=0 and OUT_REG=1/WRITE_FIRST=1) and checks both
// against a behavioural memory model with a timed queue of expected reads.
module tb_ram_dp;
  localparam int          DEPTH = 16;
  localparam logic [31:0] CV0   = 32'h0000_0000;
  localparam logic [31:0] CV1   = 32'h5A5A_0FF0;

  logic        clk;
  logic        rst_n;
  logic        clear_req;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [3:0]  rd_addr;

  ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus0 ();
  ram_dp_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus1 ();

  assign bus0.clear_req = clear_req;
  assign bus0.wr_en     = wr_en;
  assign bus0.wr_addr   = wr_addr;
  assign bus0.wr_be     = wr_be;
  assign bus0.wr_data   = wr_data;
  assign bus0.rd_en     = rd_en;
  assign bus0.rd_addr   = rd_addr;
  assign bus1.clear_req = clear_req;
  assign bus1.wr_en     = wr_en;
  assign bus1.wr_addr   = wr_addr;
  assign bus1.wr_be     = wr_be;
  assign bus1.wr_data   = wr_data;
  assign bus1.rd_en     = rd_en;
  assign bus1.rd_addr   = rd_addr;

  ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(0), .WRITE_FIRST(0), .CLEAR_VALUE(CV0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .OUT_REG(1), .WRITE_FIRST(1), .CLEAR_VALUE(CV1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  logic [31:0] model_mem [2][DEPTH];
  bit          model_busy;
  int          clr_idx;
  rd_t         q0[$];
  rd_t         q1[$];
  logic [31:0] held [2];
  int          cyc;
  int          total;
  int          bad;

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] merge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_output();
    logic v0;
    logic v1;
    v0 = (q0.size() > 0) && (q0[0].due == cyc);
    v1 = (q1.size() > 0) && (q1[0].due == cyc);
    if (v0) begin held[0] = q0[0].data; void'(q0.pop_front()); end
    if (v1) begin held[1] = q1[0].data; void'(q1.pop_front()); end
    check("busy0",     32'(bus0.busy),     32'(model_busy));
    check("busy1",     32'(bus1.busy),     32'(model_busy));
    check("rd_valid0", 32'(bus0.rd_valid), 32'(v0));
    check("rd_valid1", 32'(bus1.rd_valid), 32'(v1));
    check("rd_data0",  bus0.rd_data,       held[0]);
    check("rd_data1",  bus1.rd_data,       held[1]);
  endtask

  // One clock edge: update the model for this edge, then sample on the falling edge
  task automatic step();
    logic [31:0] old_w [2];
    logic [31:0] new_w [2];
    rd_t e;
    if (rst_n) begin
      if (!model_busy) begin
        for (int d = 0; d < 2; d++) begin
          old_w[d] = model_mem[d][rd_addr];
          new_w[d] = merge(model_mem[d][wr_addr], wr_data, wr_be);
        end
        if (rd_en) begin
          e.due  = cyc + 1;
          e.data = old_w[0];
          q0.push_back(e);
          e.due  = cyc + 2;
          e.data = (wr_en && (wr_addr == rd_addr)) ? new_w[1] : old_w[1];
          q1.push_back(e);
        end
        if (wr_en) for (int d = 0; d < 2; d++) model_mem[d][wr_addr] = new_w[d];
        if (clear_req) begin
          model_busy = 1'b1;
          clr_idx    = 0;
        end
      end else begin
        model_mem[0][clr_idx] = CV0;
        model_mem[1][clr_idx] = CV1;
        if (clr_idx == DEPTH - 1) model_busy = 1'b0;
        clr_idx++;
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_output();
  endtask

  task automatic apply_stimulus(logic cr, logic we, logic [3:0] wa, logic [3:0] be,
                                logic [31:0] wd, logic re, logic [3:0] ra);
    clear_req = cr;
    wr_en     = we;
    wr_addr   = wa;
    wr_be     = be;
    wr_data   = wd;
    rd_en     = re;
    rd_addr   = ra;
    step();
  endtask

  task automatic idle_step();
    apply_stimulus(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  // Asserts reset away from the clock edge, checks the asynchronous values, holds it, releases it
  task automatic do_reset(int cycles);
    clear_req = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rst_n     = 1'b0;
    #1;
    model_busy = 1'b1;
    clr_idx    = 0;
    q0.delete();
    q1.delete();
    held[0] = 32'd0;
    held[1] = 32'd0;
    check("rst_busy0",     32'(bus0.busy),     32'd1);
    check("rst_busy1",     32'(bus1.busy),     32'd1);
    check("rst_rd_valid0", 32'(bus0.rd_valid), 32'd0);
    check("rst_rd_valid1", 32'(bus1.rd_valid), 32'd0);
    check("rst_rd_data0",  bus0.rd_data,       32'd0);
    check("rst_rd_data1",  bus1.rd_data,       32'd0);
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  // Counts the busy window while optionally hammering the write/read ports
  task automatic run_clear(string tag, logic do_writes);
    int n;
    n = 0;
    while (bus0.busy === 1'b1 && n < 40) begin
      if (do_writes) apply_stimulus(1'b0, 1'b1, 4'(n), 4'hF, 32'hFFFF_FFFF, 1'b1, 4'(n));
      else           idle_step();
      n++;
    end
    check(tag, 32'(n), 32'd16);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) apply_stimulus(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
    repeat (3) idle_step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    clear_req = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_be = 4'd0;
    wr_data = 32'd0;  rd_en = 1'b0; rd_addr = 4'd0;
    for (int a = 0; a < DEPTH; a++) begin
      model_mem[0][a] = 32'd0;
      model_mem[1][a] = 32'd0;
    end
    $display("[TB] reset and initial clear");
    do_reset(3);
    run_clear("clear_len_after_reset", 1'b0);
    read_all();

    $display("[TB] byte enables");
    apply_stimulus(1'b0, 1'b1, 4'd3, 4'hF, 32'h1122_3344, 1'b0, 4'd0);
    apply_stimulus(1'b0, 1'b1, 4'd3, 4'b0101, 32'hAABB_CCDD, 1'b0, 4'd0);
    apply_stimulus(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd3);
    check("be_data_lat1", bus0.rd_data, 32'h11BB_33DD);
    check("be_valid_lat1", 32'(bus0.rd_valid), 32'd1);
    idle_step();
    check("be_data_lat2", bus1.rd_data, 32'h11BB_33DD);
    idle_step();

    $display("[TB] collision");
    apply_stimulus(1'b0, 1'b1, 4'd5, 4'hF, 32'hCAFE_F00D, 1'b1, 4'd5);
    check("coll_read_first", bus0.rd_data, 32'h0000_0000);
    idle_step();
    check("coll_write_first", bus1.rd_data, 32'hCAFE_F00D);
    idle_step();

    $display("[TB] back-to-back reads");
    apply_stimulus(1'b0, 1'b1, 4'd0, 4'hF, 32'h0000_00AA, 1'b0, 4'd0);
    apply_stimulus(1'b0, 1'b1, 4'd1, 4'hF, 32'h0000_00BB, 1'b0, 4'd0);
    apply_stimulus(1'b0, 1'b1, 4'd2, 4'hF, 32'h0000_00CC, 1'b0, 4'd0);
    apply_stimulus(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd0);
    apply_stimulus(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd1);
    check("b2b_first", bus1.rd_data, 32'h0000_00AA);
    apply_stimulus(1'b0, 1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2);
    check("b2b_second", bus1.rd_data, 32'h0000_00BB);
    idle_step();
    check("b2b_third", bus1.rd_data, 32'h0000_00CC);
    check("b2b_third_valid", 32'(bus1.rd_valid), 32'd1);
    repeat (2) idle_step();

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++) begin
      apply_stimulus(1'($urandom_range(0, 59) == 0), 1'($urandom), 4'($urandom), 4'($urandom),
                     $urandom, 1'($urandom), 4'($urandom));
    end
    idle_step();
    for (int k = 0; k < 40 && bus0.busy === 1'b1; k++) idle_step();
    repeat (2) idle_step();

    $display("[TB] clear request after fill");
    for (int a = 0; a < DEPTH; a++) apply_stimulus(1'b0, 1'b1, 4'(a), 4'hF, 32'hFFFF_FFFF, 1'b0, 4'd0);
    apply_stimulus(1'b1, 1'b1, 4'd4, 4'hF, 32'h1234_5678, 1'b1, 4'd4);
    check("clr_coincident_read", bus0.rd_data, 32'hFFFF_FFFF);
    run_clear("clear_len_on_request", 1'b1);
    read_all();

    $display("[TB] reset during clear");
    apply_stimulus(1'b1, 1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
    repeat (7) idle_step();
    do_reset(2);
    run_clear("clear_len_after_midreset", 1'b0);
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
